// File: rtl/store_rmw.sv
// store_rmw: store unit turning SB/SH into read-modify-write sequences on a word-only data memory.
// Every output is a flop; requests are sampled only while the unit is idle and ready.
module store_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              misaligned
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        off_r;
  logic [15:0]       data_r;
  logic [1:0]        size_r;
  logic [ADDR_W-3:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              req_ready_r;
  logic              mem_re_r;
  logic              mem_we_r;
  logic              done_r;
  logic              misaligned_r;
  logic              accept_s;
  logic              bad_align_s;

  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane merge; source bits above the stored width are dropped.
  function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [15:0] src,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] w;
    w = rd;
    case (size)
      SIZE_B: w[{off, 3'b000} +: 8] = src[7:0];
      SIZE_H: begin
        if (off[1]) begin
          w[31:16] = src;
        end else begin
          w[15:0] = src;
        end
      end
      default: w = rd;
    endcase
    return w;
  endfunction

  assign accept_s    = req_valid & req_ready_r;
  assign bad_align_s = bad_align(req_size, req_addr[1:0]);

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (bad_align_s) begin
          state_next_s = ERR;
        end else if (req_size == SIZE_W) begin
          state_next_s = WR;
        end else begin
          state_next_s = RD;
        end
      end
      RD:      state_next_s = WAIT;
      WAIT:    state_next_s = WR;
      WR:      state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and strobes, registered from the next state so they line up with it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      mem_re_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      req_ready_r  <= (state_next_s == IDLE);
      mem_re_r     <= (state_next_s == RD);
      mem_we_r     <= (state_next_s == WR);
      done_r       <= (state_next_s == WR) || (state_next_s == ERR);
      misaligned_r <= (state_next_s == ERR);
    end
  end

  // Request latch, memory address and write-data register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      off_r       <= 2'b00;
      data_r      <= 16'h0000;
      size_r      <= 2'b00;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        off_r      <= req_addr[1:0];
        data_r     <= req_data[15:0];
        size_r     <= req_size;
        mem_addr_r <= req_addr[ADDR_W-1:2];
      end
      if (accept_s && !bad_align_s && (req_size == SIZE_W)) begin
        mem_wdata_r <= req_data;
      end else if (state_r == WAIT) begin
        mem_wdata_r <= merge_store(mem_rdata, data_r, size_r, off_r);
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign mem_addr   = mem_addr_r;
  assign mem_re     = mem_re_r;
  assign mem_we     = mem_we_r;
  assign mem_wdata  = mem_wdata_r;
  assign done       = done_r;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_store_rmw.sv
// Self-checking bench for store_rmw: directed scenarios plus randomized stores
// compared against a mask-and-shift reference model and a small word memory.
module tb_store_rmw;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              misaligned;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:15];

  int                obs_re_cyc, obs_re_cnt, obs_we_cyc, obs_we_cnt;
  int                obs_done_cyc, obs_done_cnt, obs_mis_cyc, obs_mis_cnt, obs_ready_cyc;
  logic [ADDR_W-3:0] obs_re_addr, obs_we_addr;
  logic [31:0]       obs_we_data;

  always #5 clock = ~clock;

  store_rmw #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .done(done), .misaligned(misaligned)
  );

  // Memory model: read data valid the cycle after mem_re, garbage otherwise
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
    else        mem_rdata <= $urandom;
  end

  function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [1:0] size);
    int sh;
    logic [31:0] mask;
    if (size == 2'd2) return data;
    if (size == 2'd0) begin
      sh = 8 * int'(addr % 4);
      mask = 32'h0000_00FF << sh;
    end else begin
      sh = 16 * int'((addr % 4) / 2);
      mask = 32'h0000_FFFF << sh;
    end
    return (old & ~mask) | ((data << sh) & mask);
  endfunction

  // Present one request, scramble inputs after acceptance, record what the DUT does per cycle
  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    obs_re_cyc = 0; obs_re_cnt = 0; obs_we_cyc = 0; obs_we_cnt = 0;
    obs_done_cyc = 0; obs_done_cnt = 0; obs_mis_cyc = 0; obs_mis_cnt = 0; obs_ready_cyc = 0;
    obs_re_addr = '0; obs_we_addr = '0; obs_we_data = 32'h0;
    @(negedge clock);
    req_addr = addr; req_data = data; req_size = size; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (mem_re) begin
        obs_re_cnt++;
        if (obs_re_cyc == 0) begin obs_re_cyc = c; obs_re_addr = mem_addr; end
      end
      if (mem_we) begin
        obs_we_cnt++;
        if (obs_we_cyc == 0) begin obs_we_cyc = c; obs_we_addr = mem_addr; obs_we_data = mem_wdata; end
      end
      if (done) begin obs_done_cnt++; if (obs_done_cyc == 0) obs_done_cyc = c; end
      if (misaligned) begin obs_mis_cnt++; if (obs_mis_cyc == 0) obs_mis_cyc = c; end
      if (req_ready) begin obs_ready_cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_data = 32'h1234_5678; req_size = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({req_ready, mem_re, mem_we, done, misaligned} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_strobes cyc=%0d got=%b exp=00000", c, {req_ready, mem_re, mem_we, done, misaligned});
      end
      checks++;
      if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_data cyc=%0d got addr=%h wdata=%h exp 0", c, mem_addr, mem_wdata);
      end
    end
    @(negedge clock);
    req_valid = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_sw();
    issue(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
    checks++;
    if (obs_we_cyc !== 1 || obs_done_cyc !== 1 || obs_we_cnt !== 1) begin
      failures++;
      $display("FAIL sw_timing got we=%0d done=%0d n=%0d exp 1/1/1", obs_we_cyc, obs_done_cyc, obs_we_cnt);
    end
    checks++;
    if (obs_we_addr !== 30'h4 || obs_we_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sw_data got addr=%h data=%h exp 4/deadbeef", obs_we_addr, obs_we_data);
    end
    checks++;
    if (obs_re_cnt !== 0 || obs_mis_cnt !== 0 || obs_ready_cyc !== 2) begin
      failures++;
      $display("FAIL sw_misc got re=%0d mis=%0d ready=%0d exp 0/0/2", obs_re_cnt, obs_mis_cnt, obs_ready_cyc);
    end
  endtask

  task automatic test_sb_lanes();
    logic [31:0] exp_w [4];
    exp_w = '{32'h1122_33AB, 32'h1122_AB44, 32'h11AB_3344, 32'hAB22_3344};
    for (int k = 0; k < 4; k++) begin
      mem[2] = 32'h1122_3344;
      issue(32'h8 + 32'(k), 32'hFFFF_FFAB, 2'b00);
      checks++;
      if (obs_re_cyc !== 1 || obs_re_addr !== 30'h2 || obs_re_cnt !== 1) begin
        failures++;
        $display("FAIL sb_read lane=%0d got cyc=%0d addr=%h n=%0d exp 1/2/1", k, obs_re_cyc, obs_re_addr, obs_re_cnt);
      end
      checks++;
      if (obs_we_cyc !== 3 || obs_done_cyc !== 3 || obs_ready_cyc !== 4) begin
        failures++;
        $display("FAIL sb_timing lane=%0d got we=%0d done=%0d ready=%0d exp 3/3/4", k, obs_we_cyc, obs_done_cyc, obs_ready_cyc);
      end
      checks++;
      if (obs_we_data !== exp_w[k] || obs_we_addr !== 30'h2) begin
        failures++;
        $display("FAIL sb_data lane=%0d got %h@%h exp %h@2", k, obs_we_data, obs_we_addr, exp_w[k]);
      end
    end
  endtask

  task automatic test_sh();
    logic [31:0] exp_w [2];
    logic [31:0] offs [2];
    exp_w = '{32'hCAFE_3344, 32'h1122_CAFE};
    offs  = '{32'd2, 32'd0};
    for (int k = 0; k < 2; k++) begin
      mem[3] = 32'h1122_3344;
      issue(32'hC + offs[k], 32'h0000_CAFE, 2'b01);
      checks++;
      if (obs_we_data !== exp_w[k] || obs_we_cyc !== 3 || obs_re_cyc !== 1) begin
        failures++;
        $display("FAIL sh_data off=%0d got %h we=%0d re=%0d exp %h 3/1", offs[k], obs_we_data, obs_we_cyc, obs_re_cyc, exp_w[k]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h21, 32'h22, 32'h20};
    sizes = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      issue(addrs[k], 32'h5555_AAAA, sizes[k]);
      checks++;
      if (obs_done_cyc !== 1 || obs_mis_cyc !== 1 || obs_done_cnt !== 1 || obs_mis_cnt !== 1) begin
        failures++;
        $display("FAIL mis_flags case=%0d got done=%0d mis=%0d nd=%0d nm=%0d exp 1/1/1/1", k, obs_done_cyc, obs_mis_cyc, obs_done_cnt, obs_mis_cnt);
      end
      checks++;
      if (obs_re_cnt !== 0 || obs_we_cnt !== 0 || obs_ready_cyc !== 2) begin
        failures++;
        $display("FAIL mis_access case=%0d got re=%0d we=%0d ready=%0d exp 0/0/2", k, obs_re_cnt, obs_we_cnt, obs_ready_cyc);
      end
    end
  endtask

  task automatic test_reset_midop();
    int late_we;
    late_we = 0;
    @(negedge clock);
    req_addr = 32'h15; req_data = 32'h0000_0077; req_size = 2'b00; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_re !== 1'b1) begin failures++; $display("FAIL midop_re got=%b exp=1", mem_re); end
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({mem_we, done, req_ready} !== 3'b000) begin
      failures++;
      $display("FAIL midop_in_reset got we/done/ready=%b exp 000", {mem_we, done, req_ready});
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL midop_ready got=%b exp=1", req_ready); end
    for (int c = 0; c < 4; c++) begin
      if (mem_we) late_we++;
      @(negedge clock);
    end
    checks++;
    if (late_we !== 0) begin failures++; $display("FAIL midop_no_write got=%0d exp=0", late_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old, da, db;
    int          n, we_cyc [2];
    logic [31:0] we_dat [2];
    bit          sent;
    mem[6] = $urandom; old = mem[6];
    da = $urandom; db = $urandom;
    n = 0; sent = 1'b0;
    @(negedge clock);
    req_addr = 32'h30; req_data = da; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_addr = 32'h1A; req_data = db; req_size = 2'b00;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (mem_we) begin
        if (n < 2) begin we_cyc[n] = c; we_dat[n] = mem_wdata; end
        n++;
      end
      if (req_ready && !sent) begin
        sent = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
      end
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=2", n);
    end else begin
      checks++;
      if (we_cyc[0] !== 1 || we_cyc[1] !== 5) begin
        failures++;
        $display("FAIL b2b_timing got %0d,%0d exp 1,5", we_cyc[0], we_cyc[1]);
      end
      checks++;
      if (we_dat[0] !== da || we_dat[1] !== ref_write(old, 32'h1A, db, 2'b00)) begin
        failures++;
        $display("FAIL b2b_data got %h,%h exp %h,%h", we_dat[0], we_dat[1], da, ref_write(old, 32'h1A, db, 2'b00));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, old, exp_w;
    logic [1:0]  size;
    logic [39:0] got_t, exp_t;
    bit          err, sub;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 63));
      size = 2'($urandom_range(0, 3));
      data = $urandom;
      old  = mem[addr[5:2]];
      err  = ref_err(addr, size);
      sub  = !err && (size != 2'd2);
      lat  = sub ? 3 : 1;
      exp_w = ref_write(old, addr, data, size);
      issue(addr, data, size);
      got_t = {8'(obs_done_cyc), 8'(obs_ready_cyc), 8'(obs_re_cnt), 8'(obs_we_cnt), 8'(obs_mis_cnt)};
      exp_t = {8'(lat), 8'(lat + 1), 8'(sub ? 1 : 0), 8'(err ? 0 : 1), 8'(err ? 1 : 0)};
      checks++;
      if (got_t !== exp_t) begin
        failures++;
        $display("FAIL rnd_timing i=%0d a=%h s=%0d got=%h exp=%h", i, addr, size, got_t, exp_t);
      end
      if (!err) begin
        checks++;
        if (obs_we_data !== exp_w || obs_we_addr !== addr[31:2] || obs_we_cyc !== lat) begin
          failures++;
          $display("FAIL rnd_write i=%0d a=%h s=%0d got %h@%h c%0d exp %h@%h c%0d", i, addr, size,
                   obs_we_data, obs_we_addr, obs_we_cyc, exp_w, addr[31:2], lat);
        end
        mem[addr[5:2]] = exp_w;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_sw();
    test_sb_lanes();
    test_sh();
    test_misaligned();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
